// File: rtl/bcd_serial_add_ctrl_if.sv
// bcd_serial_add_ctrl_if: start/busy/done operand and result bundle (carries "sub" when BCD_CTRL_SUB_EN is defined)
interface bcd_serial_add_ctrl_if #(
    parameter int NDIG = 4
);
    logic              start;
    logic [4*NDIG-1:0] a;
    logic [4*NDIG-1:0] b;
    logic              cin;
`ifdef BCD_CTRL_SUB_EN
    logic              sub;
`endif
    logic              busy;
    logic              done;
    logic [4*NDIG-1:0] sum;
    logic              cout;
    logic              error;

    modport master (
`ifdef BCD_CTRL_SUB_EN
        output sub,
`endif
        output start, a, b, cin,
        input  busy, done, sum, cout, error
    );

    modport slave (
`ifdef BCD_CTRL_SUB_EN
        input  sub,
`endif
        input  start, a, b, cin,
        output busy, done, sum, cout, error
    );
endinterface

// File: rtl/bcd_serial_add_ctrl.sv
// bcd_serial_add_ctrl: digit-serial BCD adder controller, LSD first; BCD_CTRL_SUB_EN adds ten's-complement subtraction
module bcd_serial_add_ctrl #(
    parameter int NDIG = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    bcd_serial_add_ctrl_if.slave bus
);
    localparam int W  = 4 * NDIG;
    localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d, cout_q, cout_d, err_q, err_d;
    logic            busy_q, busy_d, done_q, done_d;
    logic            bad, c_cap, dc;
    logic [W-1:0]    b_cap;
    logic [3:0]      da, db, rd;
    logic [4:0]      s;

    always_comb begin
        bad   = 1'b0;
        b_cap = bus.b;
        c_cap = bus.cin;
`ifdef BCD_CTRL_SUB_EN
        c_cap = bus.sub ? 1'b1 : bus.cin;
`endif
        for (int i = 0; i < NDIG; i++) begin
            bad = bad | (bus.a[4*i +: 4] > 4'd9) | (bus.b[4*i +: 4] > 4'd9);
`ifdef BCD_CTRL_SUB_EN
            b_cap[4*i +: 4] = bus.sub ? 4'd9 - bus.b[4*i +: 4] : bus.b[4*i +: 4];
`endif
        end
        da      = a_q[{idx_q, 2'b00} +: 4];
        db      = b_q[{idx_q, 2'b00} +: 4];
        s       = {1'b0, da} + {1'b0, db} + {4'b0, carry_q};
        dc      = s > 5'd9;
        rd      = dc ? 4'(s - 5'd10) : s[3:0];
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (bus.start) begin
                a_d     = bus.a;
                b_d     = b_cap;
                carry_d = c_cap;
                sum_d   = '0;
                cout_d  = 1'b0;
                err_d   = bad;
                idx_d   = '0;
                state_d = bad ? DONE : ADD;
            end
            ADD: begin
                sum_d[{idx_q, 2'b00} +: 4] = rd;
                carry_d = dc;
                if (idx_q == IW'(NDIG - 1)) begin
                    cout_d  = dc;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d == ADD;
        done_d = state_d == DONE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;
    assign bus.error = err_q;
endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// tb_bcd_serial_add_ctrl: randomized self-checking bench against a decimal-arithmetic reference model
module tb_bcd_serial_add_ctrl;
    localparam int NDIG = 4;
    localparam int W    = 4 * NDIG;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bcd_serial_add_ctrl_if #(.NDIG(NDIG)) bus ();

    bcd_serial_add_ctrl #(.NDIG(NDIG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic sub,
                                  output logic [W-1:0] s, output logic co, output logic er);
        longint av = 0, bv = 0, m = 1, r;
        er = 1'b0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            av = av * 10 + longint'(a[4*i +: 4]);
            bv = bv * 10 + longint'(b[4*i +: 4]);
            m  = m * 10;
            if (a[4*i +: 4] > 9 || b[4*i +: 4] > 9) er = 1'b1;
        end
        r  = sub ? av - bv + m : av + bv + longint'(cin);
        co = r >= m;
        r  = r % m;
        s  = '0;
        for (int i = 0; i < NDIG; i++) begin
            s[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
        if (er) begin
            s  = '0;
            co = 1'b0;
        end
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] v;
        for (int i = 0; i < NDIG; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    // Issues one request and reports when done arrived (cycles after the accepting edge).
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub, input bit poke,
                          output int n_done, output int n_busy,
                          output logic [W-1:0] s, output logic co, output logic er);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
`ifdef BCD_CTRL_SUB_EN
        bus.sub   = sub;
`endif
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.cin   = 1'($urandom);
        n_done = 0;
        n_busy = 0;
        for (int n = 1; n <= 3 * NDIG + 10; n++) begin
            @(negedge clk);
            if (poke && n == 2) begin
                bus.start = 1'b1;
                bus.a     = 16'h5555;
                bus.b     = 16'h5555;
            end
            if (poke && n == 3) bus.start = 1'b0;
            if (bus.busy) n_busy++;
            if (bus.done) begin
                n_done = n;
                s  = bus.sum;
                co = bus.cout;
                er = bus.error;
                break;
            end
        end
        if (n_done == 0) begin
            s  = 'x;
            co = 1'bx;
            er = 1'bx;
        end
    endtask

    task automatic check_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic sub, input bit poke);
        int nd, nb;
        logic [W-1:0] s, es;
        logic co, er, eco, eer;
        model(a, b, cin, sub, es, eco, eer);
        run_op(a, b, cin, sub, poke, nd, nb, s, co, er);
        checks++;
        if (nd !== (eer ? 1 : NDIG + 1)) begin
            errors++;
            $display("FAIL %s done_cycle got %0d exp %0d", nm, nd, eer ? 1 : NDIG + 1);
        end
        checks++;
        if (nb !== (eer ? 0 : NDIG)) begin
            errors++;
            $display("FAIL %s busy_cycles got %0d exp %0d", nm, nb, eer ? 0 : NDIG);
        end
        checks++;
        if ({s, co, er} !== {es, eco, eer}) begin
            errors++;
            $display("FAIL %s a=%h b=%h cin=%b sub=%b got sum=%h cout=%b err=%b exp sum=%h cout=%b err=%b",
                     nm, a, b, cin, sub, s, co, er, es, eco, eer);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.sum, bus.cout, bus.error} !== {(W + 4){1'b0}}) begin
            errors++;
            $display("FAIL reset busy=%b done=%b sum=%h cout=%b err=%b exp all 0",
                     bus.busy, bus.done, bus.sum, bus.cout, bus.error);
        end
    endtask

    task automatic test_vectors();
        check_op("v1234_5678", 16'h1234, 16'h5678, 1'b0, 1'b0, 1'b0);
        check_op("v9999_0001", 16'h9999, 16'h0001, 1'b0, 1'b0, 1'b0);
        check_op("v9999_9999c", 16'h9999, 16'h9999, 1'b1, 1'b0, 1'b0);
        check_op("v0000_0000", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_error();
        check_op("err_12A4", 16'h12A4, 16'h0000, 1'b0, 1'b0, 1'b0);
        check_op("err_bF", 16'h0000, 16'hF000, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_hold();
        logic [W-1:0] s0;
        s0 = bus.sum;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.done, bus.busy, bus.sum} !== {2'b00, s0}) begin
            errors++;
            $display("FAIL hold done=%b busy=%b sum=%h exp 0 0 %h", bus.done, bus.busy, bus.sum, s0);
        end
    endtask

    task automatic test_ignore_start();
        check_op("ignore_busy_start", 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        check_op("b2b_first", 16'h4321, 16'h0789, 1'b0, 1'b0, 1'b0);
        check_op("b2b_second", 16'h0500, 16'h0500, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_abort();
        int seen = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'h8765;
        bus.b     = 16'h4321;
        bus.cin   = 1'b0;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.sum, bus.cout, bus.error} !== {(W + 4){1'b0}}) begin
            errors++;
            $display("FAIL abort busy=%b done=%b sum=%h cout=%b err=%b exp all 0",
                     bus.busy, bus.done, bus.sum, bus.cout, bus.error);
        end
        repeat (8) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort_no_done active_cycles got %0d exp 0", seen);
        end
        check_op("after_abort", 16'h0042, 16'h0058, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        for (int k = 0; k < 40; k++) begin
            a = rand_bcd();
            b = rand_bcd();
            if ($urandom_range(0, 9) == 0) a[4*$urandom_range(0, NDIG - 1) +: 4] = 4'($urandom_range(10, 15));
            if ($urandom_range(0, 9) == 0) b[4*$urandom_range(0, NDIG - 1) +: 4] = 4'($urandom_range(10, 15));
            check_op("random", a, b, 1'($urandom), 1'b0, 1'b0);
        end
    endtask

`ifdef BCD_CTRL_SUB_EN
    task automatic test_sub();
        logic [W-1:0] a, b;
        check_op("sub_5000_1234", 16'h5000, 16'h1234, 1'b0, 1'b1, 1'b0);
        check_op("sub_0000_0001", 16'h0000, 16'h0001, 1'b1, 1'b1, 1'b0);
        check_op("sub_err", 16'h0000, 16'h00B0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 20; k++) begin
            a = rand_bcd();
            b = rand_bcd();
            check_op("sub_random", a, b, 1'($urandom), 1'b1, 1'b0);
        end
    endtask
`endif

    initial begin
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
`ifdef BCD_CTRL_SUB_EN
        bus.sub   = 1'b0;
`endif
        test_reset();
        test_vectors();
        test_hold();
        test_error();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        test_random();
`ifdef BCD_CTRL_SUB_EN
        test_sub();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
